// File: rtl/ram_multitap_delay_line.sv
// ============================================================================
// ram_multitap_delay_line : block-RAM delay line, tap k delays by k*D ce-cycles
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_multitap_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DELAY  = 640,
  parameter int TAPS       = 2,
  parameter int LEN_BITS   = $clog2(MAX_DELAY + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [LEN_BITS-1:0]        delay_len,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic [TAPS*DATA_WIDTH-1:0] data_out,
  output logic [TAPS-1:0]            tap_valid
);

  localparam int DEPTH    = MAX_DELAY - 1;
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(TAPS * MAX_DELAY + 1);

  localparam logic [LEN_BITS-1:0] MIN_LEN = LEN_BITS'(3);
  localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_DELAY);

  logic                accept;
  logic [LEN_BITS-1:0] len_clamped;
  logic [LEN_BITS-1:0] d_eff;
  logic [LEN_BITS-1:0] ptr_last;
  logic [PTR_BITS-1:0] ptr;
  logic [CNT_BITS-1:0] fill_cnt;
  logic [CNT_BITS-1:0] fill_max;

  assign accept = ce & ~rst;

  always_comb begin
    len_clamped = delay_len;
    if (delay_len < MIN_LEN) begin
      len_clamped = MIN_LEN;
    end else if (delay_len > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  // Ring of D-1 entries plus the output register gives exactly D cycles.
  assign ptr_last = d_eff - LEN_BITS'(2);
  assign fill_max = CNT_BITS'(TAPS) * CNT_BITS'(d_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_eff <= len_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (ce) begin
      if (LEN_BITS'(ptr) == ptr_last) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (ce && (fill_cnt != fill_max)) begin
      fill_cnt <= fill_cnt + CNT_BITS'(1);
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] tap_in;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  valid_q;
    logic [CNT_BITS-1:0]   threshold;
    logic                  reached;

    // Each tap is fed from the previous tap's RAM read register, which is
    // one stage ahead of that tap's output register.
    if (k == 0) begin : g_head
      assign tap_in = data_in;
    end else begin : g_chain
      assign tap_in = g_tap[k-1].rd_q;
    end

    assign threshold = CNT_BITS'(k + 1) * CNT_BITS'(d_eff);
    assign reached   = (fill_cnt >= threshold);

    always_ff @(posedge clk) begin
      if (accept) begin
        mem[ptr] <= tap_in;
        rd_q     <= mem[ptr];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else if (ce) begin
        valid_q <= reached;
        out_q   <= reached ? rd_q : '0;
      end
    end

    assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = out_q;
    assign tap_valid[k]                         = valid_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_multitap_delay_line.sv
// ============================================================================
// tb_ram_multitap_delay_line : scoreboard bench for the multi-tap delay line
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_multitap_delay_line;

  localparam int DW   = 8;
  localparam int MAXD = 24;
  localparam int TAPS = 2;
  localparam int LB   = $clog2(MAXD + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic [LB-1:0]      delay_len;
  logic [DW-1:0]      data_in;
  logic [TAPS*DW-1:0] data_out;
  logic [TAPS-1:0]    tap_valid;

  typedef struct packed {
    logic [TAPS*DW-1:0] dout;
    logic [TAPS-1:0]    vld;
  } exp_t;

  exp_t          sb[$];
  exp_t          last_exp;
  logic [DW-1:0] hist[$];
  int            model_d;
  int            checks = 0;
  int            errors = 0;

  ram_multitap_delay_line #(
    .DATA_WIDTH(DW),
    .MAX_DELAY (MAXD),
    .TAPS      (TAPS),
    .LEN_BITS  (LB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .delay_len(delay_len),
    .data_in  (data_in),
    .data_out (data_out),
    .tap_valid(tap_valid)
  );

  always #5 clk = ~clk;

  // Expected outputs for the newest accepted sample, from the sample history.
  function automatic exp_t model_out();
    exp_t e;
    int   n;
    e = '0;
    n = hist.size() - 1;
    for (int k = 1; k <= TAPS; k++) begin
      if (n >= k * model_d) begin
        e.dout[(k-1)*DW +: DW] = hist[n - k * model_d];
        e.vld[k-1]             = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty, got %0d entries expected 1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (data_out === e.dout) else begin
        errors++;
        $error("FAIL %s data_out: got %h expected %h", tag, data_out, e.dout);
      end
      checks++;
      assert (tap_valid === e.vld) else begin
        errors++;
        $error("FAIL %s tap_valid: got %b expected %b", tag, tap_valid, e.vld);
      end
    end
  endtask

  task automatic step(input logic ce_v, input logic [DW-1:0] din, input string tag);
    rst     = 1'b0;
    ce      = ce_v;
    data_in = din;
    if (ce_v) begin
      hist.push_back(din);
      last_exp = model_out();
    end
    sb.push_back(last_exp);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_reset(input int len, input logic ce_v, input logic [DW-1:0] din);
    rst       = 1'b1;
    ce        = ce_v;
    data_in   = din;
    delay_len = LB'(len);
    hist.delete();
    model_d   = (len < 3) ? 3 : ((len > MAXD) ? MAXD : len);
    last_exp  = '0;
    sb.push_back(last_exp);
    @(posedge clk);
    #1;
    check_out($sformatf("reset len=%0d", len));
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ce        = 1'b0;
    data_in   = '0;
    delay_len = LB'(5);

    // D=5, continuous stream.
    do_reset(5, 1'b0, 8'h00);
    do_reset(5, 1'b0, 8'h00);
    for (int i = 0; i < 14; i++) begin
      step(1'b1, DW'(i), $sformatf("d5 n=%0d", i));
      if (i == 12) begin
        checks++;
        assert (data_out[7:0] === 8'd7 && data_out[15:8] === 8'd2) else begin
          errors++;
          $error("FAIL d5 cycle12: got tap1=%0d tap2=%0d expected tap1=7 tap2=2",
                 data_out[7:0], data_out[15:8]);
        end
      end
    end

    // D=5 with ce toggling: delay counts only accepted samples.
    do_reset(5, 1'b0, 8'h00);
    for (int i = 0; i < 24; i++) begin
      step(((i % 2) == 0), DW'(i), $sformatf("toggle i=%0d", i));
    end

    // Clamping at both ends.
    do_reset(1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, DW'(8'h40 + i), $sformatf("clamp3 n=%0d", i));
    end
    do_reset(MAXD + 7, 1'b0, 8'h00);
    for (int i = 0; i < MAXD + 3; i++) begin
      step(1'b1, DW'(8'h80 + i), $sformatf("clampmax n=%0d", i));
    end

    // Mid-stream reset to a shorter delay.
    do_reset(8, 1'b0, 8'h00);
    for (int i = 0; i < 42; i++) begin
      step(1'b1, DW'(8'h10 + i), $sformatf("d8 n=%0d", i));
    end
    do_reset(4, 1'b0, 8'h00);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, DW'(8'hC0 + i), $sformatf("d4 restart n=%0d", i));
    end

    // delay_len changes without reset must be ignored.
    do_reset(6, 1'b0, 8'h00);
    delay_len = LB'(20);
    for (int i = 0; i < 26; i++) begin
      step(1'b1, DW'(8'h20 + 3 * i), $sformatf("d6 hold n=%0d", i));
    end

    // Sample presented together with reset is discarded.
    do_reset(4, 1'b1, 8'hAA);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DW'(8'h01 + i), $sformatf("rst+ce n=%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_multitap_delay_line.md
# ram_multitap_delay_line

Runtime-programmable, multi-tap delay line built on inferred block RAM for the SGM datapath. It generalises the fixed single-output RAM delay line. Each of TAPS outputs presents the input stream delayed by an integer multiple of a line length chosen at reset. The typical use is stacking the previous image rows for the path-cost aggregation window. Per-tap valid flags and output zeroing give downstream stages clean start-of-frame behaviour without separate fill counters.

## Interface
- DATA_WIDTH, 8: width of one sample.
- MAX_DELAY, 640: largest supported line length D, in ce-cycles. Must be ≥ 3.
- TAPS, 2: number of delayed outputs. Tap k (1..TAPS) delays by k*D.
- LEN_BITS, clog2(MAX_DELAY+1): width of delay_len.
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high; acts regardless of ce.
- ce  input  1  clock enable; one sample is accepted per cycle with ce=1.
- delay_len  input  LEN_BITS  line length D; sampled only on cycles with rst=1.
- data_in  input  DATA_WIDTH  input sample.
- data_out  output  TAPS*DATA_WIDTH  tap k occupies bits [k*DATA_WIDTH-1 : (k-1)*DATA_WIDTH].
- tap_valid  output  TAPS  bit k-1 high when tap k carries real data.

## Operation
- Internal storage: one circular RAM per tap. Depth is MAX_DELAY-1, matching the 2-cycle read latency of ram_inference. All taps share one write/read pointer. Each tap's RAM input is the previous tap's delayed output; tap 1's input is data_in.
- Pointer behaviour:
  - Advances on every ce=1 cycle.
  - Wraps to 0 after reaching D_eff-2, so the total latency per tap is exactly D_eff.
- Delay register D_eff:
  - Loaded from delay_len on every rst=1 cycle.
  - Values below 3 are clamped to 3. Values above MAX_DELAY are clamped to MAX_DELAY.
  - delay_len is ignored while rst=0; changing it mid-stream has no effect.
- Fill counter:
  - Counts accepted samples since reset.
  - Saturates at TAPS*D_eff and does not wrap.
  - tap_valid[k-1] = (count ≥ k*D_eff).
- Output gating: data_out tap k is forced to 0 while tap_valid[k-1]=0. Stale RAM contents never leak out.
- ce=0: pointer, counter, RAM writes and all outputs hold their values.
- Reset mid-operation:
  - Pointer and counter are cleared, D_eff is reloaded, and all tap_valid bits drop.
  - RAM contents are not cleared; the output gating hides them.
- rst and ce both high: reset wins, and the sample is not accepted.

## Timing
- Cycles are counted in ce-cycles. Let n = index of the ce=1 cycle since reset deassertion, with the first accepted sample at n=0.
- In ce-cycle n, tap k presents data_in from ce-cycle n-k*D_eff, provided n ≥ k*D_eff. Otherwise it presents 0.
- tap_valid[k-1] rises in the same cycle that tap k first presents sample 0, i.e. ce-cycle n = k*D_eff.
- Reset values, from the cycle after rst is sampled high:
  - data_out = 0.
  - tap_valid = 0.
  - pointer = 0.
  - counter = 0.
- Outputs are registered.
- No combinational path from data_in or ce to any output.
- Throughput: one sample per ce-cycle, no stalls. ce may toggle arbitrarily; delay is measured in ce-cycles, not clocks.

## Test plan
- D=5, TAPS=2, ce=1 constantly, data_in=0,1,2,…:
  - tap_valid = 00 for n<5, 01 for 5≤n<10, 11 from n=10.
  - In cycle 12, tap1=7 and tap2=2.
  - data_out is 0 on each tap before its valid bit rises.
- Same stream with ce toggling 1,0,1,0…:
  - Outputs hold on ce=0 cycles.
  - Tap1 in the 9th ce=1 cycle equals the value accepted in the 4th ce=1 cycle (n=8 → x[3]); delay counts only ce cycles.
- delay_len=1, then delay_len=MAX_DELAY+7 at reset:
  - The first is clamped to D_eff=3; tap1 valid first appears at n=3.
  - The second is clamped to MAX_DELAY; tap1 valid first appears at n=MAX_DELAY.
- D=8, stream running past n=40:
  - Assert rst for 1 cycle with delay_len=4.
  - Next cycle: data_out=0 and tap_valid=00.
  - After restart, tap1 valid at n=4 and output equals the post-reset sample 0; no pre-reset data appears.
- D=6 at reset, then delay_len changed to 20 with rst=0: delay stays 6 (tap1 in cycle n equals x[n-6] across 3 full pointer wraps).
- rst=1 and ce=1 together with data_in=0xAA: that sample never appears on any tap.
